// File: rtl/prod_accumulator_if.sv
// Product-stream / result-port bundle for prod_accumulator.
// master = producer/consumer side, slave = the accumulator.
interface prod_accumulator_if #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 80,
  parameter int CNT_W  = 9
);
  logic signed [PROD_W-1:0] prod;
  logic                     prod_valid;
  logic                     prod_last;
  logic                     in_ready;
  logic signed [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]         sum_terms;
  logic                     sum_valid;
  logic                     sum_ready;
  logic                     ovf;
  logic                     drop_err;

  modport master (
    output prod, prod_valid, prod_last, sum_ready,
    input  in_ready, sum, sum_terms, sum_valid, ovf, drop_err
  );

  modport slave (
    input  prod, prod_valid, prod_last, sum_ready,
    output in_ready, sum, sum_terms, sum_valid, ovf, drop_err
  );
endinterface

// File: rtl/prod_accumulator.sv
// Accumulates a signed product stream into one wide sum per vector and holds it on a valid/ready port.
// Define PROD_ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module prod_accumulator #(
  parameter int PROD_W    = 64,
  parameter int ACC_W     = 80,
  parameter int MAX_TERMS = 256,
  parameter int CNT_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  prod_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    ovf_int_q, ovf_int_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]        sum_terms_q, sum_terms_d;
  logic                    ovf_q, ovf_d;
  logic                    drop_err_q, drop_err_d;

  logic                    in_ready;
  logic                    sum_valid;
  logic                    accept;
  logic                    last_term;
  logic signed [ACC_W-1:0] prod_ext, add_res, acc_sum;
  logic                    add_ovf;

  assign accept    = bus.prod_valid && in_ready;
  assign last_term = bus.prod_last || (count_q == CNT_W'(MAX_TERMS - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_int_q   <= 1'b0;
      sum_q       <= '0;
      sum_terms_q <= '0;
      ovf_q       <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_int_q   <= ovf_int_d;
      sum_q       <= sum_d;
      sum_terms_q <= sum_terms_d;
      ovf_q       <= ovf_d;
      drop_err_q  <= drop_err_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (bus.prod_last || MAX_TERMS == 1) ? HOLD : ACCUM;
      ACCUM:   if (accept && last_term) state_d = HOLD;
      HOLD:    if (bus.sum_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    in_ready  = (state_q != HOLD);
    sum_valid = (state_q == HOLD);
  end

  // Signed add with overflow detection; saturation picks the rail by the shared operand sign.
  always_comb begin
    prod_ext = {{(ACC_W-PROD_W){bus.prod[PROD_W-1]}}, bus.prod};
    add_res  = acc_q + prod_ext;
    add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (add_res[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef PROD_ACC_SATURATE_EN
    if (add_ovf) acc_sum = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else         acc_sum = add_res;
`else
    acc_sum = add_res;
`endif
  end

  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_int_d   = ovf_int_q;
    sum_d       = sum_q;
    sum_terms_d = sum_terms_q;
    ovf_d       = ovf_q;
    drop_err_d  = drop_err_q | (bus.prod_valid & ~in_ready);

    unique case (state_q)
      IDLE: if (accept) begin
        acc_d     = prod_ext;
        count_d   = CNT_W'(1);
        ovf_int_d = 1'b0;
      end
      ACCUM: if (accept) begin
        acc_d     = acc_sum;
        count_d   = count_q + CNT_W'(1);
        ovf_int_d = ovf_int_q | add_ovf;
      end
      HOLD: if (bus.sum_ready) begin
        acc_d     = '0;
        count_d   = '0;
        ovf_int_d = 1'b0;
      end
      default: ;
    endcase

    // Capture the finished vector on the edge that enters HOLD.
    if (state_q != HOLD && state_d == HOLD) begin
      sum_d       = acc_d;
      sum_terms_d = count_d;
      ovf_d       = ovf_int_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.sum_valid = sum_valid;
  assign bus.sum       = sum_q;
  assign bus.sum_terms = sum_terms_q;
  assign bus.ovf       = ovf_q;
  assign bus.drop_err  = drop_err_q;

endmodule
